clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//   N-channel programmable clock-enable generator; replaces ripple-clocked flop-chain dividers.
//   Fully synchronous to clk: outputs are a 1-cycle tick strobe and a square wave per channel,
//   not derived clocks. Sits between the board clock and slow consumers (LED blink, scan, debounce).
//   Divisors are runtime-programmable via a valid/ready port; updates take effect glitch-free at wrap.
// PARAMETERS
//   N_CH     4         number of independent channels (1..16)
//   CNT_W    24        counter/divisor width; max divisor 2**CNT_W-1
//   DIV_RST  524288    reset divisor of every channel (period 2**19 clk cycles)
// PORTS
//   clk        in   1             system clock; all state on rising edge
//   rst        in   1             reset, synchronous, active-high
//   en         in   N_CH          per-channel run enable
//   cfg_valid  in   1             divisor write request
//   cfg_ready  out  1             write can be accepted (combinational)
//   cfg_ch     in   4             target channel index
//   cfg_div    in   CNT_W         new full-period divisor, legal range 2..2**CNT_W-1
//   cfg_err    out  1             1-cycle pulse: write rejected
//   pend       out  N_CH          channel has a divisor update waiting for wrap
//   tick       out  N_CH          1-cycle strobe once per period
//   sq         out  N_CH          square wave, period = divisor
//   sync       in   1             (CLKDIV_SYNC_EN only) phase-align all channels
// BEHAVIOUR
//   - Reset: cnt=0, div=DIV_RST, pend=0, tick=0, sq=0, cfg_err=0 for all channels. rst beats all.
//   - Per channel, edge with en=1: if cnt==div-1 -> cnt<=0, tick<=1; else cnt<=cnt+1, tick<=0.
//   - sq registered from next count: sq <= (cnt_next >= (div>>1)). Even div: 50% duty;
//     odd div: low for div>>1 cycles, high for remaining.
//   - With en high from the first edge, tick first asserts in the cycle after edge DIV, then every DIV.
//   - en=0 at an edge: cnt<=0, tick<=0, sq<=0; pending divisor applied immediately (pend<=0).
//   - cfg_ready = (cfg_ch >= N_CH) | ~pend[cfg_ch]. Accept on cfg_valid & cfg_ready.
//   - Accepted with cfg_ch>=N_CH or cfg_div<2: not stored, cfg_err=1 for one cycle.
//   - Accepted legal write: div_pend[ch]<=cfg_div, pend[ch]<=1. Never alters current period.
//   - Pending applied on the wrap edge (cnt==div-1): div<=div_pend, pend<=0; the next period uses it.
//   - Write accepted on the same edge as that channel's wrap: goes to pending, applied at the
//     FOLLOWING wrap (current wrap keeps old div).
//   - Write while pend[ch]=1: cfg_ready=0, request stalls; writer holds cfg_valid/cfg_ch/cfg_div.
//   - Counter never exceeds div-1; no wrap-around past 2**CNT_W-1 possible.
//   - rst asserted mid-period: everything returns to reset values at that edge, pending dropped.
// CONFIGURATION
//   CLKDIV_SYNC_EN defined: port sync present. sync=1 at an edge (rst=0): every channel cnt<=0,
//     tick<=0, sq<=0, pending divisors applied, pend<=0; cfg accept on the same edge still stores
//     into pending. Priority rst > sync > en/count.
//   CLKDIV_SYNC_EN undefined: no sync port; channels align only via rst or en.
// TESTING
//   - rst 2 cycles, en=0 -> tick=0, sq=0, pend=0, cfg_ready=1; en=1 -> first tick after 524288 edges.
//   - cfg ch0 div=4, en[0]=1 -> tick every 4 cycles, sq pattern 0,0,1,1 repeating.
//   - ch1 running div=10, write div=6 at cnt=3 -> pend[1]=1, cfg_ready=0 for ch1 until wrap;
//     one 10-cycle period completes, then 6-cycle periods.
//   - cfg_div=1 to ch2, then cfg_ch=7 (N_CH=4) -> cfg_err pulses once each, divisors unchanged.
//   - ch3 div=5 -> sq low 2 / high 3; drop en[3] mid-period -> tick=0, sq=0 next cycle, restart clean.
//   - (CLKDIV_SYNC_EN) ch0 div=4, ch1 div=8 offset; pulse sync -> ticks coincide every 8 cycles.

Source files
------------

// File: rtl/clk_div_multi.sv
// clk_div_multi: per-channel tick strobe and square wave, registered one clk after the counting edge.
// cfg_ready drops while the target channel holds an unapplied divisor; CLKDIV_SYNC_EN adds the sync input.
module clk_div_multi #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 24,
    parameter int DIV_RST = 524288
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_err,
    output logic [N_CH-1:0]  pend,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq
`ifdef CLKDIV_SYNC_EN
    ,
    input  logic             sync
`endif
);

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    logic [CNT_W-1:0] cnt      [N_CH];
    logic [CNT_W-1:0] div      [N_CH];
    logic [CNT_W-1:0] div_pend [N_CH];

    logic [15:0]     pend_ext;
    logic            ch_bad;
    logic            div_bad;
    logic            cfg_acc;
    logic            cfg_wr;
    logic            restart_all;
    logic [N_CH-1:0] wr_sel;
    logic [N_CH-1:0] wrap;

`ifdef CLKDIV_SYNC_EN
    assign restart_all = sync;
`else
    assign restart_all = 1'b0;
`endif

    // Out-of-range channels are always ready so a bad write is accepted and flagged, never stalled.
    always_comb begin
        pend_ext           = '0;
        pend_ext[N_CH-1:0] = pend;
    end

    assign ch_bad    = (32'(cfg_ch) >= 32'(N_CH));
    assign div_bad   = (cfg_div < TWO);
    assign cfg_ready = ch_bad | ~pend_ext[cfg_ch];
    assign cfg_acc   = cfg_valid & cfg_ready;
    assign cfg_wr    = cfg_acc & ~ch_bad & ~div_bad;

    always_comb begin
        wr_sel = '0;
        wrap   = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_sel[i] = cfg_wr & (32'(cfg_ch) == 32'(i));
            wrap[i]   = (cnt[i] == div[i] - ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
            pend    <= '0;
            tick    <= '0;
            sq      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i]      <= '0;
                div[i]      <= DIV_INIT;
                div_pend[i] <= DIV_INIT;
            end
        end else begin
            cfg_err <= cfg_acc & (ch_bad | div_bad);
            for (int i = 0; i < N_CH; i++) begin
                if (restart_all || !en[i]) begin
                    cnt[i]  <= '0;
                    tick[i] <= 1'b0;
                    sq[i]   <= 1'b0;
                end else if (wrap[i]) begin
                    cnt[i]  <= '0;
                    tick[i] <= 1'b1;
                    sq[i]   <= 1'b0;
                end else begin
                    cnt[i]  <= cnt[i] + ONE;
                    tick[i] <= 1'b0;
                    sq[i]   <= ((cnt[i] + ONE) >= (div[i] >> 1));
                end
                // Divisor only changes when the count restarts, so a period is never cut short.
                if (pend[i] && (restart_all || !en[i] || wrap[i])) begin
                    div[i]  <= div_pend[i];
                    pend[i] <= 1'b0;
                end
                if (wr_sel[i]) begin
                    div_pend[i] <= cfg_div;
                    pend[i]     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed stimulus queues expected tick/cfg_err cycles; a negedge monitor matches them against the DUT.
// sq, pend and cfg_ready are compared inline against hand-computed values.
module tb_clk_div_multi;
    localparam int N_CH    = 4;
    localparam int CNT_W   = 24;
    localparam int DIV_RST = 40;
    localparam int ERR_BIT = N_CH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_CH-1:0]  en = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [3:0]       cfg_ch = '0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_err;
    logic [N_CH-1:0]  pend;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  sq;
`ifdef CLKDIV_SYNC_EN
    logic             sync = 1'b0;
`endif

    typedef struct {
        int cyc;
        int ch;
    } ev_t;

    ev_t sb[$];
    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;
    int  sq_div4 [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int  sq_div5 [8] = '{0, 1, 1, 1, 0, 0, 1, 1};

    clk_div_multi #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_RST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .pend      (pend),
        .tick      (tick),
        .sq        (sq)
`ifdef CLKDIV_SYNC_EN
        ,
        .sync      (sync)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(input int at, input int ch);
        ev_t e;
        e.cyc = at;
        e.ch  = ch;
        sb.push_back(e);
    endtask

    task automatic to_cyc(input int t);
        if (cyc > t) begin
            checks++;
            failures++;
            $display("FAIL schedule cyc=%0d target=%0d", cyc, t);
        end
        while (cyc < t) @(negedge clk);
    endtask

    // Holds the request until accepted; acc is the accepting edge number.
    task automatic cfg_write(input int ch, input int dv, input bit bad, output int acc);
        int n;
        n         = 0;
        acc       = -1;
        cfg_valid = 1'b1;
        cfg_ch    = 4'(ch);
        cfg_div   = CNT_W'(dv);
        #1;
        while (acc < 0 && n < 64) begin
            if (cfg_ready) begin
                acc = cyc + 1;
                if (bad) expect_ev(acc, ERR_BIT);
            end
            @(negedge clk);
            n++;
        end
        cfg_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL cfg_timeout ch=%0d got=no_accept expected=accept", ch);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [N_CH:0] expv;
        logic [N_CH:0] actv;
        expv = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                expv[sb[i].ch] = 1'b1;
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL stale_event ch=%0d got=unseen expected=cyc%0d", sb[i].ch, sb[i].cyc);
                sb.delete(i);
            end
        end
        actv = {cfg_err, tick};
        if (expv != '0 || actv != '0) begin
            checks++;
            if (actv != expv) begin
                failures++;
                $display("FAIL events cyc=%0d got=%b expected=%b", cyc, actv, expv);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=hang expected=finish", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int acc;

        @(negedge clk);
        @(negedge clk);
        chk("rst_tick", int'(tick), 0);
        chk("rst_sq", int'(sq), 0);
        chk("rst_pend", int'(pend), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_cfg_err", int'(cfg_err), 0);
        rst = 1'b0;

        // ch0: reset divisor first, then a queued divisor of 4 takes over at the wrap
        c  = cyc;
        en = 4'b0001;
        expect_ev(c + 40, 0);
        expect_ev(c + 44, 0);
        expect_ev(c + 48, 0);
        to_cyc(c + 5);
        cfg_write(0, 4, 1'b0, acc);
        chk("a_acc", acc, c + 6);
        chk("a_pend", int'(pend), 1);
        chk("a_ready_blocked", int'(cfg_ready), 0);
        to_cyc(c + 40);
        chk("a_pend_applied", int'(pend), 0);
        chk("a_ready_free", int'(cfg_ready), 1);
        for (int k = 1; k <= 8; k++) begin
            to_cyc(c + 40 + k);
            chk("a_sq_div4", int'(sq[0]), sq_div4[k-1]);
        end
        to_cyc(c + 50);
        en = 4'b0000;

        // ch1: div 10, mid-period update to 6, then a stalled write of 3
        cfg_write(1, 10, 1'b0, acc);
        c = acc + 1;
        to_cyc(c);
        chk("b_pend_idle", int'(pend), 0);
        en = 4'b0010;
        expect_ev(c + 10, 1);
        expect_ev(c + 16, 1);
        expect_ev(c + 19, 1);
        expect_ev(c + 22, 1);
        expect_ev(c + 25, 1);
        to_cyc(c + 3);
        cfg_write(1, 6, 1'b0, acc);
        chk("b_acc", acc, c + 4);
        chk("b_pend", int'(pend[1]), 1);
        chk("b_ready_blocked", int'(cfg_ready), 0);
        to_cyc(c + 6);
        cfg_write(1, 3, 1'b0, acc);
        chk("b_stall_acc", acc, c + 11);
        chk("b_pend2", int'(pend[1]), 1);
        to_cyc(c + 26);
        en = 4'b0000;

        // illegal writes: divisor 1 and channel 7 are flagged and not stored
        cfg_write(2, 1, 1'b1, acc);
        chk("c_pend_div1", int'(pend), 0);
        cfg_write(7, 100, 1'b1, acc);
        chk("c_pend_ch7", int'(pend), 0);
        c  = cyc;
        en = 4'b0100;
        expect_ev(c + 40, 2);
        to_cyc(c + 41);
        en = 4'b0000;

        // ch3: odd divisor, write landing on the wrap edge, en drop and restart
        cfg_write(3, 5, 1'b0, acc);
        c = acc + 1;
        to_cyc(c);
        chk("d_pend_idle", int'(pend), 0);
        en = 4'b1000;
        expect_ev(c + 5, 3);
        expect_ev(c + 10, 3);
        expect_ev(c + 15, 3);
        expect_ev(c + 28, 3);
        for (int k = 1; k <= 8; k++) begin
            to_cyc(c + k);
            chk("d_sq_div5", int'(sq[3]), sq_div5[k-1]);
        end
        to_cyc(c + 9);
        chk("d_sq_k9", int'(sq[3]), 1);
        cfg_write(3, 7, 1'b0, acc);
        chk("d_acc_on_wrap", acc, c + 10);
        chk("d_sq_k10", int'(sq[3]), 0);
        chk("d_pend_set", int'(pend[3]), 1);
        to_cyc(c + 15);
        chk("d_pend_applied", int'(pend[3]), 0);
        to_cyc(c + 18);
        chk("d_sq_div7_high", int'(sq[3]), 1);
        en = 4'b0000;
        to_cyc(c + 19);
        chk("d_sq_dropped", int'(sq[3]), 0);
        chk("d_tick_dropped", int'(tick[3]), 0);
        to_cyc(c + 21);
        en = 4'b1000;
        to_cyc(c + 29);
        en = 4'b0000;

`ifdef CLKDIV_SYNC_EN
        // ch0 div 4 and ch1 div 8 started out of phase, then aligned by sync
        cfg_write(1, 8, 1'b0, acc);
        c = acc + 1;
        to_cyc(c);
        en = 4'b0001;
        expect_ev(c + 4, 0);
        expect_ev(c + 10, 0);
        expect_ev(c + 14, 0);
        expect_ev(c + 18, 0);
        expect_ev(c + 22, 0);
        expect_ev(c + 14, 1);
        expect_ev(c + 22, 1);
        to_cyc(c + 2);
        en = 4'b0011;
        to_cyc(c + 5);
        sync = 1'b1;
        to_cyc(c + 6);
        sync = 1'b0;
        chk("e_sq_synced", int'(sq), 0);
        to_cyc(c + 23);
        en = 4'b0000;
`endif

        // reset mid-period drops the pending divisor and restores the reset divisor
        c  = cyc;
        en = 4'b0001;
        expect_ev(c + 4, 0);
        expect_ev(c + 47, 0);
        to_cyc(c + 5);
        cfg_write(0, 9, 1'b0, acc);
        chk("f_pend_before_rst", int'(pend[0]), 1);
        rst = 1'b1;
        to_cyc(c + 7);
        rst = 1'b0;
        chk("f_pend_rst", int'(pend), 0);
        chk("f_sq_rst", int'(sq), 0);
        chk("f_ready_rst", int'(cfg_ready), 1);
        to_cyc(c + 48);
        en = 4'b0000;

        to_cyc(cyc + 5);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
